vram_arbiter: RTL and testbench

- Shares one single-port video RAM (iCE40 SPRAM-style, 1-cycle read latency) between two requesters.
- The display scan-out fetch has priority; the host read/write port gets the remaining slots.
- A starvation guard guarantees the host a slot after a bounded wait.
- Sits between video_main's scan-out fetch logic and the VRAM macro, all in the PLL `clk` domain.

---
 rtl/vram_arbiter.sv | 153 +++++++++++++++
 tb/tb_vram_arbiter.sv | 495 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vram_arbiter.sv
// vram_arbiter: shares one single-port VRAM (1-cycle read latency) between the
// display scan-out fetch (priority) and a host read/write port. A saturating
// wait counter forces a host grant after HOST_MAX_WAIT consecutive denials.
module vram_arbiter #(
    parameter int unsigned ADDR_W        = 14,
    parameter int unsigned DATA_W        = 16,
    parameter int unsigned HOST_MAX_WAIT = 8
) (
    input  logic              clk,
    input  logic              rst_ni,

    // Display scan-out fetch port
    input  logic              disp_req_i,
    input  logic [ADDR_W-1:0] disp_addr_i,
    output logic              disp_ack_o,
    output logic              disp_valid_o,
    output logic [DATA_W-1:0] disp_data_o,

    // Host read/write port
    input  logic              host_req_i,
    input  logic              host_we_i,
    input  logic [ADDR_W-1:0] host_addr_i,
    input  logic [DATA_W-1:0] host_wdata_i,
    output logic              host_ack_o,
    output logic              host_rvalid_o,
    output logic [DATA_W-1:0] host_rdata_o,

    // VRAM macro port
    output logic              mem_ce_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i
);

    localparam logic [7:0] MaxWait = 8'(HOST_MAX_WAIT);

    // Grant decision
    logic host_grant;
    logic disp_grant;
    logic starve;

    // Starvation counter
    logic [7:0] wait_cnt_q;
    logic [7:0] wait_cnt_d;

    // Registered memory drive
    logic              mem_ce_q;
    logic              mem_ce_d;
    logic              mem_we_q;
    logic              mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [ADDR_W-1:0] mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q;
    logic [DATA_W-1:0] mem_wdata_d;

    // Read-return tag pipeline: bit 1 = display read, bit 0 = host read
    logic [1:0] tag1_q;
    logic [1:0] tag1_d;
    logic [1:0] tag2_q;
    logic [1:0] tag2_d;

    assign starve = (wait_cnt_q == MaxWait);

    // Single grant per cycle: host wins when starved or display is idle
    always_comb begin
        host_grant = host_req_i && (starve || !disp_req_i);
        disp_grant = disp_req_i && !host_grant;
    end

    // Wait counter: counts consecutive denied host cycles, saturating at the limit
    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (!host_req_i || host_grant) begin
            wait_cnt_d = 8'd0;
        end else if (wait_cnt_q < MaxWait) begin
            wait_cnt_d = wait_cnt_q + 8'd1;
        end
    end

    // Wait counter register
    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            wait_cnt_q <= 8'd0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
        end
    end

    // Next memory drive: winner's access; buses hold when there is no grant
    always_comb begin
        mem_ce_d    = host_grant || disp_grant;
        mem_we_d    = host_grant && host_we_i;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if (host_grant) begin
            mem_addr_d = host_addr_i;
            if (host_we_i) begin
                mem_wdata_d = host_wdata_i;
            end
        end else if (disp_grant) begin
            mem_addr_d = disp_addr_i;
        end
    end

    // Memory drive registers
    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            mem_ce_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            mem_ce_q    <= mem_ce_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    // Tag pipeline next state: stage 1 tracks the slot being presented to the
    // VRAM, stage 2 lines up with the returning read data
    always_comb begin
        tag1_d = {disp_grant, host_grant && !host_we_i};
        tag2_d = tag1_q;
    end

    // Tag pipeline registers; reset drops any access in flight
    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            tag1_q <= 2'b00;
            tag2_q <= 2'b00;
        end else begin
            tag1_q <= tag1_d;
            tag2_q <= tag2_d;
        end
    end

    // Output drive: acks are combinational, everything else registered or pass-through
    always_comb begin
        disp_ack_o    = disp_grant;
        host_ack_o    = host_grant;
        mem_ce_o      = mem_ce_q;
        mem_we_o      = mem_we_q;
        mem_addr_o    = mem_addr_q;
        mem_wdata_o   = mem_wdata_q;
        disp_valid_o  = tag2_q[1];
        host_rvalid_o = tag2_q[0];
        disp_data_o   = mem_rdata_i;
        host_rdata_o  = mem_rdata_i;
    end

endmodule

// File: tb/tb_vram_arbiter.sv
// Testbench for vram_arbiter: directed scenario tasks plus a randomized run,
// all cross-checked every cycle against a transaction-level reference model.
module tb_vram_arbiter;

    localparam int AW = 14;
    localparam int DW = 16;
    localparam int MW = 8;

    logic          clk = 1'b0;
    logic          rst_ni = 1'b0;
    logic          disp_req = 1'b0;
    logic [AW-1:0] disp_addr = '0;
    logic          host_req = 1'b0;
    logic          host_we = 1'b0;
    logic [AW-1:0] host_addr = '0;
    logic [DW-1:0] host_wdata = '0;
    logic          disp_ack_o, disp_valid_o, host_ack_o, host_rvalid_o;
    logic [DW-1:0] disp_data_o, host_rdata_o;
    logic          mem_ce_o, mem_we_o;
    logic [AW-1:0] mem_addr_o;
    logic [DW-1:0] mem_wdata_o;
    logic [DW-1:0] mem_rdata;

    int n_checks = 0;
    int n_fail = 0;
    bit mon_en = 1'b0;

    always #5 clk = ~clk;

    vram_arbiter #(
        .ADDR_W(AW),
        .DATA_W(DW),
        .HOST_MAX_WAIT(MW)
    ) dut (
        .clk          (clk),
        .rst_ni       (rst_ni),
        .disp_req_i   (disp_req),
        .disp_addr_i  (disp_addr),
        .disp_ack_o   (disp_ack_o),
        .disp_valid_o (disp_valid_o),
        .disp_data_o  (disp_data_o),
        .host_req_i   (host_req),
        .host_we_i    (host_we),
        .host_addr_i  (host_addr),
        .host_wdata_i (host_wdata),
        .host_ack_o   (host_ack_o),
        .host_rvalid_o(host_rvalid_o),
        .host_rdata_o (host_rdata_o),
        .mem_ce_o     (mem_ce_o),
        .mem_we_o     (mem_we_o),
        .mem_addr_o   (mem_addr_o),
        .mem_wdata_o  (mem_wdata_o),
        .mem_rdata_i  (mem_rdata)
    );

    // Single-port VRAM with one cycle of read latency
    logic [DW-1:0] vram [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (mem_ce_o) begin
            if (mem_we_o) vram[mem_addr_o] <= mem_wdata_o;
            else          mem_rdata <= vram[mem_addr_o];
        end
    end

    // Reference model: expected memory contents, and queues of expected
    // memory drives and read returns keyed by the cycle they are due
    typedef struct {
        int            due;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } mem_exp_t;
    typedef struct {
        int            due;
        logic          disp;
        logic [DW-1:0] data;
    } ret_exp_t;

    logic [DW-1:0] ref_mem [0:(1<<AW)-1];
    mem_exp_t mq[$];
    ret_exp_t rq[$];

    initial begin : monitor
        int  cyc;
        int  h_age;
        bit  exp_h, exp_d;
        cyc = 0;
        h_age = 0;
        forever begin
            @(negedge clk);
            if (!rst_ni) begin
                mq.delete();
                rq.delete();
                h_age = 0;
            end else if (mon_en) begin
                cyc++;
                exp_h = host_req && (h_age >= MW || !disp_req);
                exp_d = disp_req && !exp_h;
                n_checks++;
                if (host_ack_o !== exp_h) begin
                    n_fail++;
                    $display("FAIL model host_ack cyc %0d: got %b want %b", cyc, host_ack_o, exp_h);
                end
                n_checks++;
                if (disp_ack_o !== exp_d) begin
                    n_fail++;
                    $display("FAIL model disp_ack cyc %0d: got %b want %b", cyc, disp_ack_o, exp_d);
                end
                if (mq.size() > 0 && mq[0].due == cyc) begin
                    n_checks++;
                    if (mem_ce_o !== 1'b1 || mem_we_o !== mq[0].we || mem_addr_o !== mq[0].addr ||
                        (mq[0].we && mem_wdata_o !== mq[0].wdata)) begin
                        n_fail++;
                        $display("FAIL model mem_drive cyc %0d: got ce=%b we=%b a=%h d=%h want ce=1 we=%b a=%h d=%h",
                                 cyc, mem_ce_o, mem_we_o, mem_addr_o, mem_wdata_o,
                                 mq[0].we, mq[0].addr, mq[0].wdata);
                    end
                    void'(mq.pop_front());
                end else begin
                    n_checks++;
                    if (mem_ce_o !== 1'b0 || mem_we_o !== 1'b0) begin
                        n_fail++;
                        $display("FAIL model mem_idle cyc %0d: got ce=%b we=%b want 0 0",
                                 cyc, mem_ce_o, mem_we_o);
                    end
                end
                if (rq.size() > 0 && rq[0].due == cyc) begin
                    n_checks++;
                    if (disp_valid_o !== rq[0].disp || host_rvalid_o !== !rq[0].disp ||
                        (rq[0].disp ? disp_data_o : host_rdata_o) !== rq[0].data) begin
                        n_fail++;
                        $display("FAIL model read_return cyc %0d: got dv=%b hv=%b dd=%h hd=%h want disp=%b data=%h",
                                 cyc, disp_valid_o, host_rvalid_o, disp_data_o, host_rdata_o,
                                 rq[0].disp, rq[0].data);
                    end
                    void'(rq.pop_front());
                end else begin
                    n_checks++;
                    if (disp_valid_o !== 1'b0 || host_rvalid_o !== 1'b0) begin
                        n_fail++;
                        $display("FAIL model no_return cyc %0d: got dv=%b hv=%b want 0 0",
                                 cyc, disp_valid_o, host_rvalid_o);
                    end
                end
                if (exp_h) begin
                    mq.push_back('{cyc + 1, host_we, host_addr, host_wdata});
                    if (host_we) ref_mem[host_addr] = host_wdata;
                    else         rq.push_back('{cyc + 2, 1'b0, ref_mem[host_addr]});
                end
                if (exp_d) begin
                    mq.push_back('{cyc + 1, 1'b0, disp_addr, '0});
                    rq.push_back('{cyc + 2, 1'b1, ref_mem[disp_addr]});
                end
                if (host_req && !exp_h) h_age++;
                else                    h_age = 0;
            end
        end
    end

    task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
        vram[a] <= d;
        ref_mem[a] = d;
    endtask

    task automatic idle(input int n);
        @(posedge clk); #1;
        disp_req = 1'b0;
        host_req = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset;
        rst_ni = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({mem_ce_o, mem_we_o, disp_ack_o, host_ack_o, disp_valid_o, host_rvalid_o} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b want 000000",
                     {mem_ce_o, mem_we_o, disp_ack_o, host_ack_o, disp_valid_o, host_rvalid_o});
        end
        n_checks++;
        if (mem_addr_o !== '0 || mem_wdata_o !== '0) begin
            n_fail++;
            $display("FAIL reset_bus: got a=%h d=%h want 0 0", mem_addr_o, mem_wdata_o);
        end
        @(posedge clk); #1;
        rst_ni = 1'b1;
        mon_en = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({mem_ce_o, mem_we_o, disp_ack_o, host_ack_o, disp_valid_o, host_rvalid_o} !== 6'b0) begin
            n_fail++;
            $display("FAIL idle_ctrl: got %b want 000000",
                     {mem_ce_o, mem_we_o, disp_ack_o, host_ack_o, disp_valid_o, host_rvalid_o});
        end
    endtask

    task automatic test_disp_read;
        @(posedge clk); #1;
        disp_req = 1'b1;
        disp_addr = 14'h0123;
        @(negedge clk);
        n_checks++;
        if (disp_ack_o !== 1'b1 || host_ack_o !== 1'b0) begin
            n_fail++;
            $display("FAIL disp_read_ack: got d=%b h=%b want 1 0", disp_ack_o, host_ack_o);
        end
        @(posedge clk); #1;
        disp_req = 1'b0;
        @(negedge clk);
        n_checks++;
        if (mem_ce_o !== 1'b1 || mem_we_o !== 1'b0 || mem_addr_o !== 14'h0123 || disp_ack_o !== 1'b0) begin
            n_fail++;
            $display("FAIL disp_read_mem: got ce=%b we=%b a=%h ack=%b want 1 0 0123 0",
                     mem_ce_o, mem_we_o, mem_addr_o, disp_ack_o);
        end
        @(negedge clk);
        n_checks++;
        if (disp_valid_o !== 1'b1 || disp_data_o !== 16'hBEEF || mem_ce_o !== 1'b0) begin
            n_fail++;
            $display("FAIL disp_read_data: got v=%b d=%h ce=%b want 1 beef 0",
                     disp_valid_o, disp_data_o, mem_ce_o);
        end
        @(negedge clk);
        n_checks++;
        if (disp_valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL disp_read_pulse: got v=%b want 0", disp_valid_o);
        end
    endtask

    task automatic test_host_wr_rd;
        @(posedge clk); #1;
        host_req = 1'b1;
        host_we = 1'b1;
        host_addr = 14'h0040;
        host_wdata = 16'h5A5A;
        @(negedge clk);
        n_checks++;
        if (host_ack_o !== 1'b1) begin
            n_fail++;
            $display("FAIL host_wr_ack: got %b want 1", host_ack_o);
        end
        @(posedge clk); #1;
        host_we = 1'b0;
        @(negedge clk);
        n_checks++;
        if (host_ack_o !== 1'b1 || mem_ce_o !== 1'b1 || mem_we_o !== 1'b1 ||
            mem_addr_o !== 14'h0040 || mem_wdata_o !== 16'h5A5A) begin
            n_fail++;
            $display("FAIL host_wr_mem: got ack=%b ce=%b we=%b a=%h d=%h want 1 1 1 0040 5a5a",
                     host_ack_o, mem_ce_o, mem_we_o, mem_addr_o, mem_wdata_o);
        end
        @(posedge clk); #1;
        host_req = 1'b0;
        @(negedge clk);
        n_checks++;
        if (mem_ce_o !== 1'b1 || mem_we_o !== 1'b0 || host_rvalid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL host_wr_norvalid: got ce=%b we=%b rv=%b want 1 0 0",
                     mem_ce_o, mem_we_o, host_rvalid_o);
        end
        @(negedge clk);
        n_checks++;
        if (host_rvalid_o !== 1'b1 || host_rdata_o !== 16'h5A5A) begin
            n_fail++;
            $display("FAIL host_rd_data: got rv=%b d=%h want 1 5a5a", host_rvalid_o, host_rdata_o);
        end
        @(negedge clk);
        n_checks++;
        if (host_rvalid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL host_rd_pulse: got %b want 0", host_rvalid_o);
        end
    endtask

    task automatic test_starvation;
        int w, max_w, first_w;
        bit h_ack, d_ack;
        @(posedge clk); #1;
        disp_req = 1'b1;
        disp_addr = AW'($urandom_range(0, 255));
        host_req = 1'b1;
        host_we = 1'b0;
        host_addr = AW'($urandom_range(0, 255));
        w = 0;
        max_w = 0;
        first_w = -1;
        for (int c = 0; c < 1000; c++) begin
            @(negedge clk);
            h_ack = host_ack_o;
            d_ack = disp_ack_o;
            if (h_ack) begin
                if (first_w < 0) begin
                    first_w = w;
                    n_checks++;
                    if (d_ack !== 1'b0) begin
                        n_fail++;
                        $display("FAIL starve_disp_held: got disp_ack=%b want 0", d_ack);
                    end
                end
                if (w > max_w) max_w = w;
                w = 0;
            end else begin
                w++;
            end
            @(posedge clk); #1;
            if (d_ack) disp_addr = AW'($urandom_range(0, 255));
            if (h_ack) begin
                host_we = 1'($urandom_range(0, 1));
                host_addr = AW'($urandom_range(0, 255));
                host_wdata = 16'($urandom);
            end
        end
        n_checks++;
        if (first_w != MW) begin
            n_fail++;
            $display("FAIL starve_first_latency: got %0d want %0d", first_w, MW);
        end
        n_checks++;
        if (max_w > MW || w > MW) begin
            n_fail++;
            $display("FAIL starve_max_latency: got %0d/%0d want <= %0d", max_w, w, MW);
        end
        idle(4);
    endtask

    task automatic test_simultaneous;
        @(posedge clk); #1;
        disp_req = 1'b1;
        disp_addr = 14'h0011;
        host_req = 1'b1;
        host_we = 1'b0;
        host_addr = 14'h0012;
        @(negedge clk);
        n_checks++;
        if (disp_ack_o !== 1'b1 || host_ack_o !== 1'b0) begin
            n_fail++;
            $display("FAIL simul_first: got d=%b h=%b want 1 0", disp_ack_o, host_ack_o);
        end
        @(posedge clk); #1;
        disp_req = 1'b0;
        @(negedge clk);
        n_checks++;
        if (disp_ack_o !== 1'b0 || host_ack_o !== 1'b1) begin
            n_fail++;
            $display("FAIL simul_second: got d=%b h=%b want 0 1", disp_ack_o, host_ack_o);
        end
        @(posedge clk); #1;
        host_req = 1'b0;
        @(negedge clk);
        n_checks++;
        if (disp_valid_o !== 1'b1 || host_rvalid_o !== 1'b0 || disp_data_o !== ref_mem[14'h0011]) begin
            n_fail++;
            $display("FAIL simul_ret_disp: got dv=%b hv=%b d=%h want 1 0 %h",
                     disp_valid_o, host_rvalid_o, disp_data_o, ref_mem[14'h0011]);
        end
        @(negedge clk);
        n_checks++;
        if (disp_valid_o !== 1'b0 || host_rvalid_o !== 1'b1 || host_rdata_o !== ref_mem[14'h0012]) begin
            n_fail++;
            $display("FAIL simul_ret_host: got dv=%b hv=%b d=%h want 0 1 %h",
                     disp_valid_o, host_rvalid_o, host_rdata_o, ref_mem[14'h0012]);
        end
        idle(2);
    endtask

    task automatic test_back_to_back;
        logic [AW-1:0] a;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            disp_req = (i < 8);
            disp_addr = AW'(16 + i);
            @(negedge clk);
            if (i < 8) begin
                n_checks++;
                if (disp_ack_o !== 1'b1) begin
                    n_fail++;
                    $display("FAIL b2b_ack[%0d]: got %b want 1", i, disp_ack_o);
                end
            end
            if (i >= 2) begin
                a = AW'(16 + i - 2);
                n_checks++;
                if (disp_valid_o !== 1'b1 || disp_data_o !== ref_mem[a]) begin
                    n_fail++;
                    $display("FAIL b2b_data[%0d]: got v=%b d=%h want 1 %h", i - 2, disp_valid_o,
                             disp_data_o, ref_mem[a]);
                end
            end
        end
        @(negedge clk);
        n_checks++;
        if (disp_valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_end: got %b want 0", disp_valid_o);
        end
        idle(2);
    endtask

    task automatic test_reset_abort;
        @(posedge clk); #1;
        disp_req = 1'b1;
        disp_addr = 14'h0200;
        @(negedge clk);
        n_checks++;
        if (disp_ack_o !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_ack: got %b want 1", disp_ack_o);
        end
        @(posedge clk); #1;
        disp_req = 1'b0;
        rst_ni = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({mem_ce_o, mem_we_o, disp_ack_o, host_ack_o, disp_valid_o, host_rvalid_o} !== 6'b0 ||
            mem_addr_o !== '0 || mem_wdata_o !== '0) begin
            n_fail++;
            $display("FAIL abort_outputs: got ctrl=%b a=%h d=%h want 0",
                     {mem_ce_o, mem_we_o, disp_ack_o, host_ack_o, disp_valid_o, host_rvalid_o},
                     mem_addr_o, mem_wdata_o);
        end
        @(posedge clk); #1;
        rst_ni = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++;
            if (disp_valid_o !== 1'b0 || host_rvalid_o !== 1'b0) begin
                n_fail++;
                $display("FAIL abort_novalid[%0d]: got dv=%b hv=%b want 0 0", i, disp_valid_o,
                         host_rvalid_o);
            end
        end
        @(posedge clk); #1;
        disp_req = 1'b1;
        @(negedge clk);
        n_checks++;
        if (disp_ack_o !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_reack: got %b want 1", disp_ack_o);
        end
        @(posedge clk); #1;
        disp_req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (disp_valid_o !== 1'b1 || disp_data_o !== 16'h1234) begin
            n_fail++;
            $display("FAIL abort_reread: got v=%b d=%h want 1 1234", disp_valid_o, disp_data_o);
        end
        idle(2);
    endtask

    task automatic test_random;
        bit h_ack, d_ack;
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            h_ack = host_ack_o;
            d_ack = disp_ack_o;
            @(posedge clk); #1;
            if (disp_req && !d_ack) begin
                if ($urandom_range(0, 9) == 0) disp_req = 1'b0;
            end else begin
                disp_req = 1'($urandom_range(0, 1));
                disp_addr = AW'($urandom_range(0, 31));
            end
            if (host_req && !h_ack) begin
                if ($urandom_range(0, 15) == 0) host_req = 1'b0;
            end else begin
                host_req = 1'($urandom_range(0, 1));
                host_we = 1'($urandom_range(0, 1));
                host_addr = AW'($urandom_range(0, 31));
                host_wdata = 16'($urandom);
            end
        end
        idle(4);
    endtask

    initial begin
        for (int a = 0; a < 256; a++) preload(AW'(a), 16'($urandom));
        preload(14'h0123, 16'hBEEF);
        preload(14'h0200, 16'h1234);
        test_reset();
        test_disp_read();
        test_host_wr_rd();
        test_simultaneous();
        test_back_to_back();
        test_starvation();
        test_reset_abort();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
